// File: rtl/branch_history_table.sv
// Direct-mapped branch history table: IF-stage lookup, prediction carried down to EX, and
// resolution/training in EX. Define BHT_STATS_EN to build the branch/mispredict counters.
module branch_history_table #(
   parameter int ENTRY_BITS = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PCF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        StallE,
   input  logic        FlushE,
   input  logic [31:0] PCE,
   input  logic        BranchE,
   input  logic        BrE,
   input  logic [31:0] BranchTarget,
   output logic        BHThit,
   output logic [31:0] PrePC,
   output logic [1:0]  PredictMiss,
   output logic [31:0] BrCnt,
   output logic [31:0] MissCnt
);

   localparam int DEPTH = 1 << ENTRY_BITS;
   localparam int TAG_W = 30 - ENTRY_BITS;

   logic             r_valid  [DEPTH];
   logic [TAG_W-1:0] r_tag    [DEPTH];
   logic [31:0]      r_target [DEPTH];
   logic [1:0]       r_ctr    [DEPTH];

   logic        r_predTakenD;
   logic [31:0] r_predPCD;
   logic        r_predTakenE;
   logic [31:0] r_predPCE;

   logic [ENTRY_BITS-1:0] w_lkIdx;
   logic [TAG_W-1:0]      w_lkTag;
   logic [ENTRY_BITS-1:0] w_upIdx;
   logic [TAG_W-1:0]      w_upTag;
   logic                  w_upHit;
   logic                  w_update;
   logic                  w_unused;

   assign w_lkIdx  = PCF[ENTRY_BITS+1:2];
   assign w_lkTag  = PCF[31:ENTRY_BITS+2];
   assign w_upIdx  = PCE[ENTRY_BITS+1:2];
   assign w_upTag  = PCE[31:ENTRY_BITS+2];
   assign w_upHit  = r_valid[w_upIdx] && (r_tag[w_upIdx] == w_upTag);
   assign w_update = BranchE && !StallE;
   assign w_unused = ^{PCF[1:0], PCE[1:0]};

   assign BHThit = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag) && r_ctr[w_lkIdx][1];
   assign PrePC  = r_target[w_lkIdx];

   // Prediction travels with the instruction; flush beats stall in each stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_predTakenD <= 1'b0;
         r_predPCD    <= '0;
         r_predTakenE <= 1'b0;
         r_predPCE    <= '0;
      end else begin
         if (FlushD) begin
            r_predTakenD <= 1'b0;
            r_predPCD    <= '0;
         end else if (!StallD) begin
            r_predTakenD <= BHThit;
            r_predPCD    <= PrePC;
         end
         if (FlushE) begin
            r_predTakenE <= 1'b0;
            r_predPCE    <= '0;
         end else if (!StallE) begin
            r_predTakenE <= r_predTakenD;
            r_predPCE    <= r_predPCD;
         end
      end
   end

   // A taken branch is only correct if we predicted taken to the same target.
   always_comb begin
      PredictMiss = 2'b00;
      if (BranchE && BrE) begin
         if (!(r_predTakenE && (r_predPCE == BranchTarget)))
            PredictMiss = 2'b10;
      end else if (r_predTakenE) begin
         PredictMiss = 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b00;
         end
      end else if (w_update) begin
         if (w_upHit) begin
            if (BrE) begin
               if (r_ctr[w_upIdx] != 2'b11)
                  r_ctr[w_upIdx] <= r_ctr[w_upIdx] + 2'd1;
               r_target[w_upIdx] <= BranchTarget;
            end else if (r_ctr[w_upIdx] != 2'b00) begin
               r_ctr[w_upIdx] <= r_ctr[w_upIdx] - 2'd1;
            end
         end else if (BrE) begin
            // New taken branches start weakly taken so one repeat is predicted.
            r_valid[w_upIdx]  <= 1'b1;
            r_tag[w_upIdx]    <= w_upTag;
            r_target[w_upIdx] <= BranchTarget;
            r_ctr[w_upIdx]    <= 2'b10;
         end
      end
   end

`ifdef BHT_STATS_EN
   logic [31:0] r_brCnt;
   logic [31:0] r_missCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_brCnt   <= '0;
         r_missCnt <= '0;
      end else if (w_update) begin
         r_brCnt <= r_brCnt + 32'd1;
         if (PredictMiss != 2'b00)
            r_missCnt <= r_missCnt + 32'd1;
      end
   end

   assign BrCnt   = r_brCnt;
   assign MissCnt = r_missCnt;
`else
   assign BrCnt   = '0;
   assign MissCnt = '0;
`endif

endmodule
